// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus shared by the two result sources (A: execute, B: load/multi-cycle).
// Requester asserts valid with stable reg/data; a transfer happens on a cycle where valid && ready.
interface regfile_wb_arbiter_if #(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32
);
    logic                aValid;
    logic [ADDRSIZE-1:0] aReg;
    logic [WORDSIZE-1:0] aData;
    logic                aReady;
    logic                bValid;
    logic [ADDRSIZE-1:0] bReg;
    logic [WORDSIZE-1:0] bData;
    logic                bReady;

    modport master (
        output aValid, aReg, aData, bValid, bReg, bData,
        input  aReady, bReady
    );

    modport slave (
        input  aValid, aReg, aData, bValid, bReg, bData,
        output aReady, bReady
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port: one-entry registered output stage,
// x0 write suppression, read-after-write hazard flags and a saturating contention counter.
module regfile_wb_arbiter #(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32,
    parameter int CNTSIZE  = 16
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave wb,
    input  logic [ADDRSIZE-1:0] readReg1,
    input  logic [ADDRSIZE-1:0] readReg2,
    output logic                regWrite,
    output logic [ADDRSIZE-1:0] writeReg,
    output logic [WORDSIZE-1:0] writeData,
    output logic                hazard1,
    output logic                hazard2,
    output logic [CNTSIZE-1:0]  conflictCount,
    output logic                grantState
);

    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

    grant_t              lastGrant;
    grant_t              lastGrantNext;
    logic                aGrant;
    logic                bGrant;
    logic                xfer;
    logic [ADDRSIZE-1:0] xferReg;
    logic [WORDSIZE-1:0] xferData;

    assign wb.aReady  = aGrant;
    assign wb.bReady  = bGrant;
    assign grantState = lastGrant;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        aGrant        = 1'b0;
        bGrant        = 1'b0;
        lastGrantNext = lastGrant;
        xferReg       = wb.aReg;
        xferData      = wb.aData;
        if (!reset) begin
            if (wb.aValid && (!wb.bValid || lastGrant == GRANT_B)) begin
                aGrant        = 1'b1;
                lastGrantNext = GRANT_A;
            end else if (wb.bValid) begin
                bGrant        = 1'b1;
                lastGrantNext = GRANT_B;
                xferReg       = wb.bReg;
                xferData      = wb.bData;
            end
        end
    end

    assign xfer = aGrant || bGrant;

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant     <= GRANT_B;
            regWrite      <= 1'b0;
            writeReg      <= '0;
            writeData     <= '0;
            conflictCount <= '0;
        end else begin
            lastGrant <= lastGrantNext;
            // x0 transfers are accepted but never reach the register file.
            regWrite  <= xfer && (xferReg != '0);
            if (xfer && (xferReg != '0)) begin
                writeReg  <= xferReg;
                writeData <= xferData;
            end
            if (wb.aValid && wb.bValid && (conflictCount != {CNTSIZE{1'b1}}))
                conflictCount <= conflictCount + 1'b1;
        end
    end

    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        if (!reset && readReg1 != '0)
            hazard1 = (regWrite && writeReg == readReg1) ||
                      (wb.aValid && wb.aReg == readReg1) ||
                      (wb.bValid && wb.bReg == readReg1);
        if (!reset && readReg2 != '0)
            hazard2 = (regWrite && writeReg == readReg2) ||
                      (wb.aValid && wb.aReg == readReg2) ||
                      (wb.bValid && wb.bReg == readReg2);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter, with a behavioural register file fed by the write port.
module tb_regfile_wb_arbiter;

    localparam int ADDRSIZE = 5;
    localparam int WORDSIZE = 32;
    localparam int CNTSIZE  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDRSIZE-1:0] readReg1;
    logic [ADDRSIZE-1:0] readReg2;
    logic                regWrite;
    logic [ADDRSIZE-1:0] writeReg;
    logic [WORDSIZE-1:0] writeData;
    logic                hazard1;
    logic                hazard2;
    logic [CNTSIZE-1:0]  conflictCount;
    logic                grantState;
    logic [WORDSIZE-1:0] rf [32];

    int nAsserts = 0;
    int nFail    = 0;
    int expCount;

    regfile_wb_arbiter_if #(.ADDRSIZE(ADDRSIZE), .WORDSIZE(WORDSIZE)) wb ();

    regfile_wb_arbiter #(.ADDRSIZE(ADDRSIZE), .WORDSIZE(WORDSIZE), .CNTSIZE(CNTSIZE)) dut (
        .clk(clk), .reset(reset), .wb(wb.slave),
        .readReg1(readReg1), .readReg2(readReg2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .hazard1(hazard1), .hazard2(hazard2),
        .conflictCount(conflictCount), .grantState(grantState)
    );

    always #5 clk = ~clk;

    // Register file commits one edge after the arbiter's output stage is loaded.
    always @(posedge clk)
        if (!reset && regWrite && writeReg != 0)
            rf[writeReg] <= writeData;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1;
        wb.aValid = 1'b0; wb.aReg = '0; wb.aData = '0;
        wb.bValid = 1'b0; wb.bReg = '0; wb.bData = '0;
        readReg1 = '0; readReg2 = '0;

        // Reset state and gating of ready/hazard while reset is high
        tick();
        wb.aValid = 1'b1; wb.aReg = 5'd1; wb.aData = 32'h12345678; readReg1 = 5'd1;
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_writeReg", writeReg, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_count", conflictCount, 0);
        chk("rst_lastGrant", grantState, 1);
        chk("rst_aReady", wb.aReady, 0);
        chk("rst_hazard1", hazard1, 0);

        // Single write through A
        reset = 1'b0;
        #1;
        chk("t1_aReady", wb.aReady, 1);
        chk("t1_bReady", wb.bReady, 0);
        chk("t1_hazard1", hazard1, 1);
        tick();
        wb.aValid = 1'b0;
        #1;
        chk("t1_regWrite", regWrite, 1);
        chk("t1_writeReg", writeReg, 1);
        chk("t1_writeData", writeData, 32'h12345678);
        chk("t1_hazard1_inflight", hazard1, 1);
        tick();
        chk("t1_regWrite_drop", regWrite, 0);
        chk("t1_rf1", rf[1], 32'h12345678);

        // x0 write through B is accepted but suppressed
        readReg1 = '0; readReg2 = '0;
        wb.bValid = 1'b1; wb.bReg = '0; wb.bData = 32'hFFFFFFFF;
        #1;
        chk("t3_bReady", wb.bReady, 1);
        chk("t3_aReady", wb.aReady, 0);
        chk("t3_hazard1", hazard1, 0);
        tick();
        wb.bValid = 1'b0;
        #1;
        chk("t3_regWrite", regWrite, 0);
        chk("t3_writeReg_hold", writeReg, 1);
        chk("t3_writeData_hold", writeData, 32'h12345678);
        chk("t3_lastGrant", grantState, 1);

        // Contention: grant order A,B,A,B back-to-back
        wb.aValid = 1'b1; wb.aReg = 5'd2; wb.aData = 32'h9ABCDEF1;
        wb.bValid = 1'b1; wb.bReg = 5'd3; wb.bData = 32'h0000BEEF;
        #1;
        chk("t2_c1_aReady", wb.aReady, 1);
        chk("t2_c1_bReady", wb.bReady, 0);
        tick();
        wb.aData = 32'h11112222;
        #1;
        chk("t2_c2_writeReg", writeReg, 2);
        chk("t2_c2_writeData", writeData, 32'h9ABCDEF1);
        chk("t2_c2_bReady", wb.bReady, 1);
        chk("t2_c2_aReady", wb.aReady, 0);
        chk("t2_c2_count", conflictCount, 1);
        tick();
        wb.bReg = 5'd7; wb.bData = 32'h33334444;
        #1;
        chk("t2_c3_regWrite", regWrite, 1);
        chk("t2_c3_writeReg", writeReg, 3);
        chk("t2_c3_writeData", writeData, 32'h0000BEEF);
        chk("t2_c3_aReady", wb.aReady, 1);
        chk("t2_c3_count", conflictCount, 2);
        tick();
        chk("t2_c4_writeReg", writeReg, 2);
        chk("t2_c4_writeData", writeData, 32'h11112222);
        chk("t2_c4_bReady", wb.bReady, 1);
        chk("t2_c4_count", conflictCount, 3);
        tick();
        wb.aValid = 1'b0; wb.bValid = 1'b0;
        #1;
        chk("t2_c5_writeReg", writeReg, 7);
        chk("t2_c5_writeData", writeData, 32'h33334444);
        chk("t2_c5_count", conflictCount, 4);
        tick();
        chk("t2_regWrite_idle", regWrite, 0);
        chk("t2_count_idle", conflictCount, 4);
        chk("t2_rf2", rf[2], 32'h11112222);
        chk("t2_rf3", rf[3], 32'h0000BEEF);
        chk("t2_rf7", rf[7], 32'h33334444);

        // Hazard tracking through request and output stage
        wb.aValid = 1'b1; wb.aReg = 5'd5; wb.aData = 32'h00000055;
        readReg1 = 5'd5; readReg2 = 5'd6;
        #1;
        chk("t4_hazard1_req", hazard1, 1);
        chk("t4_hazard2_req", hazard2, 0);
        tick();
        wb.aValid = 1'b0;
        #1;
        chk("t4_regWrite", regWrite, 1);
        chk("t4_writeReg", writeReg, 5);
        chk("t4_hazard1_stage", hazard1, 1);
        chk("t4_hazard2_stage", hazard2, 0);
        tick();
        chk("t4_hazard1_clear", hazard1, 0);
        wb.bValid = 1'b1; wb.bReg = 5'd6; wb.bData = 32'h00000066;
        #1;
        chk("t4_hazard2_b", hazard2, 1);
        chk("t4_bReady", wb.bReady, 1);
        tick();
        wb.bValid = 1'b0;
        #1;
        chk("t4_b_writeReg", writeReg, 6);
        chk("t4_b_writeData", writeData, 32'h00000066);
        tick();

        // Saturation of the contention counter and steady alternation
        readReg1 = '0; readReg2 = '0;
        wb.aValid = 1'b1; wb.aReg = 5'd8; wb.aData = 32'h0000AAAA;
        wb.bValid = 1'b1; wb.bReg = 5'd9; wb.bData = 32'h0000BBBB;
        expCount = 4;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t6_aReady", wb.aReady, (i % 2 == 0) ? 1 : 0);
            chk("t6_bReady", wb.bReady, (i % 2 == 0) ? 0 : 1);
            tick();
            if (expCount < 15) expCount++;
            chk("t6_count", conflictCount, expCount);
        end
        wb.aValid = 1'b0; wb.bValid = 1'b0;
        tick();
        chk("t6_count_hold", conflictCount, 15);

        // Reset while a write sits in the output stage
        wb.aValid = 1'b1; wb.aReg = 5'd4; wb.aData = 32'hCAFEF00D;
        #1;
        chk("t5_aReady", wb.aReady, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_aReady_rst", wb.aReady, 0);
        chk("t5_bReady_rst", wb.bReady, 0);
        tick();
        wb.aValid = 1'b0;
        #1;
        chk("t5_regWrite", regWrite, 0);
        chk("t5_writeReg", writeReg, 0);
        chk("t5_count", conflictCount, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("t5_rf4", rf[4], 0);
        wb.aValid = 1'b1; wb.bValid = 1'b1;
        #1;
        chk("t5_tie_aReady", wb.aReady, 1);
        tick();
        wb.aValid = 1'b0; wb.bValid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
